ar_io_decoder: RTL and testbench



---
 rtl/ar_io_if.sv | 23 ++
 rtl/ar_io_decoder.sv | 57 +++++
 tb/tb_ar_io_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ar_io_if.sv
// Datapath-side signals of the address register / I/O decoder block.
interface ar_io_if;
    logic [15:0] ibus;
    logic [7:0]  aext;
    logic        nwrite_ar;
    logic        nmem;
    logic        nio;
    logic [23:0] ar;
    logic        nsysdev;
    logic        niodev1xx;
    logic        niodev2xx;
    logic        niodev3xx;

    modport master (
        output ibus, aext, nwrite_ar, nmem, nio,
        input  ar, nsysdev, niodev1xx, niodev2xx, niodev3xx
    );

    modport slave (
        input  ibus, aext, nwrite_ar, nmem, nio,
        output ar, nsysdev, niodev1xx, niodev2xx, niodev3xx
    );
endinterface

// File: rtl/ar_io_decoder.sv
// 24-bit address register with tri-state address-bus drive and I/O range decode.
// Optional macro IO_DECODE_EN compiles in the 0x000-0x3FF device-range decoder.
module ar_io_decoder (
    input  logic                clk,
    input  logic                nreset,
    ar_io_if.slave              bus,
    output tri   [23:0]         ab
);
    localparam int unsigned AW = 24;

    logic [AW-1:0] ar_q;
    logic          naben;

    // Address register: bank extension on top, internal bus below.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ar_q <= '0;
        end else if (!bus.nwrite_ar) begin
            ar_q <= {bus.aext, bus.ibus};
        end
    end

    assign bus.ar = ar_q;

    // Either transaction strobe puts AR on the system bus.
    assign naben = bus.nmem & bus.nio;
    assign ab    = naben ? {AW{1'bz}} : ar_q;

`ifdef IO_DECODE_EN
    logic       niocmp;
    logic [7:0] y;
    logic       unused_yhi;

    // Comparator: I/O cycle with address in the low 2 KiB window.
    assign niocmp = !(!bus.nio && (ar_q[15:11] == 5'b00000));

    // 3-to-8 demux on ar[10:8]; only the first four ranges are used.
    always_comb begin
        y = 8'hFF;
        if (!bus.nio && !niocmp) begin
            y[ar_q[10:8]] = 1'b0;
        end
    end

    assign unused_yhi    = &y[7:4];
    assign bus.nsysdev   = y[0];
    assign bus.niodev1xx = y[1];
    assign bus.niodev2xx = y[2];
    assign bus.niodev3xx = y[3];
`else
    assign bus.nsysdev   = 1'b1;
    assign bus.niodev1xx = 1'b1;
    assign bus.niodev2xx = 1'b1;
    assign bus.niodev3xx = 1'b1;
`endif

endmodule

// File: tb/tb_ar_io_decoder.sv
// Directed vector bench for ar_io_decoder; ab carries a pull-up so a floating
// bus reads back as all ones.
module tb_ar_io_decoder;
    logic clk;
    logic nreset;
    tri1 [23:0] ab;

    ar_io_if bus_if ();

    ar_io_decoder dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_if.slave),
        .ab     (ab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [23:0] FLOAT = 24'hFFFFFF;

    typedef struct {
        logic [15:0] ibus;
        logic [7:0]  aext;
        logic        nmem;
        logic        nio;
        logic [23:0] exp_ar;
        logic [23:0] exp_ab;
        logic [3:0]  exp_en;   // {niodev3xx, niodev2xx, niodev1xx, nsysdev} with decoder present
    } vec_t;

    vec_t vecs [12];

    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] en_now();
        return {bus_if.niodev3xx, bus_if.niodev2xx, bus_if.niodev1xx, bus_if.nsysdev};
    endfunction

    function automatic logic [3:0] en_exp(input logic [3:0] decoded);
`ifdef IO_DECODE_EN
        return decoded;
`else
        return (decoded == decoded) ? 4'hF : 4'hF;
`endif
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] ib, input logic [7:0] ae);
        @(negedge clk);
        bus_if.ibus      = ib;
        bus_if.aext      = ae;
        bus_if.nwrite_ar = 1'b0;
        @(posedge clk);
        #1;
        bus_if.nwrite_ar = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 8'h56, 1'b0, 1'b1, 24'h561234, 24'h561234, 4'hF};
        vecs[1]  = '{16'h1234, 8'h56, 1'b1, 1'b1, 24'h561234, FLOAT,      4'hF};
        vecs[2]  = '{16'h0042, 8'h00, 1'b1, 1'b0, 24'h000042, 24'h000042, 4'hE};
        vecs[3]  = '{16'h01FF, 8'h00, 1'b1, 1'b0, 24'h0001FF, 24'h0001FF, 4'hD};
        vecs[4]  = '{16'h0200, 8'h00, 1'b1, 1'b0, 24'h000200, 24'h000200, 4'hB};
        vecs[5]  = '{16'h03AB, 8'h00, 1'b1, 1'b0, 24'h0003AB, 24'h0003AB, 4'h7};
        vecs[6]  = '{16'h0400, 8'h00, 1'b1, 1'b0, 24'h000400, 24'h000400, 4'hF};
        vecs[7]  = '{16'h07FF, 8'h00, 1'b1, 1'b0, 24'h0007FF, 24'h0007FF, 4'hF};
        vecs[8]  = '{16'h0800, 8'h00, 1'b1, 1'b0, 24'h000800, 24'h000800, 4'hF};
        vecs[9]  = '{16'h0100, 8'hFF, 1'b1, 1'b0, 24'hFF0100, 24'hFF0100, 4'hD};
        vecs[10] = '{16'h0000, 8'h00, 1'b0, 1'b1, 24'h000000, 24'h000000, 4'hF};
        vecs[11] = '{16'h0300, 8'h12, 1'b0, 1'b0, 24'h120300, 24'h120300, 4'h7};

        nreset           = 1'b0;
        bus_if.ibus      = 16'h0;
        bus_if.aext      = 8'h0;
        bus_if.nwrite_ar = 1'b1;
        bus_if.nmem      = 1'b1;
        bus_if.nio       = 1'b1;
        #1;
        chk("reset_ar", bus_if.ar, 24'h0);
        chk("reset_ab_float", ab, FLOAT);
        chk("reset_en", 24'(en_now()), 24'hF);

        @(negedge clk);
        nreset = 1'b1;

        // Table-driven load / bus-enable / decode vectors
        for (int i = 0; i < 12; i++) begin
            bus_if.nmem = 1'b1;
            bus_if.nio  = 1'b1;
            load(vecs[i].ibus, vecs[i].aext);
            bus_if.nmem = vecs[i].nmem;
            bus_if.nio  = vecs[i].nio;
            #1;
            chk($sformatf("vec%0d_ar", i), bus_if.ar, vecs[i].exp_ar);
            chk($sformatf("vec%0d_ab", i), ab, vecs[i].exp_ab);
            chk($sformatf("vec%0d_en", i), 24'(en_now()), 24'(en_exp(vecs[i].exp_en)));
        end

        // Hold: nwrite_ar high, ibus changes across an edge
        bus_if.nmem = 1'b1;
        bus_if.nio  = 1'b1;
        load(16'h1234, 8'h56);
        @(negedge clk);
        bus_if.ibus = 16'hBEEF;
        bus_if.aext = 8'hAA;
        @(posedge clk);
        #1;
        chk("hold_ar", bus_if.ar, 24'h561234);
        chk("hold_ab_float", ab, FLOAT);

        // Consecutive reloads every cycle
        @(negedge clk);
        bus_if.nwrite_ar = 1'b0;
        bus_if.ibus = 16'h0101;
        bus_if.aext = 8'h01;
        @(posedge clk);
        #1;
        chk("reload1_ar", bus_if.ar, 24'h010101);
        bus_if.ibus = 16'h0202;
        bus_if.aext = 8'h02;
        @(posedge clk);
        #1;
        chk("reload2_ar", bus_if.ar, 24'h020202);
        bus_if.nwrite_ar = 1'b1;

        // Mid-cycle async reset, with an I/O cycle decoding address 0
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("async_rst_ar", bus_if.ar, 24'h0);
        bus_if.nio = 1'b0;
        #1;
        chk("rst_io_ab", ab, 24'h0);
        chk("rst_io_en", 24'(en_now()), 24'(en_exp(4'hE)));

        // Reset overrides load
        bus_if.nwrite_ar = 1'b0;
        bus_if.ibus = 16'h0333;
        bus_if.aext = 8'h44;
        @(posedge clk);
        #1;
        chk("rst_prio_ar", bus_if.ar, 24'h0);

        // Release mid-cycle; the next edge loads
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("rel_no_load_yet", bus_if.ar, 24'h0);
        @(posedge clk);
        #1;
        chk("rel_load_ar", bus_if.ar, 24'h440333);
        chk("rel_load_en", 24'(en_now()), 24'(en_exp(4'h7)));
        bus_if.nwrite_ar = 1'b1;
        bus_if.nio = 1'b1;
        #1;
        chk("io_off_en", 24'(en_now()), 24'hF);
        chk("io_off_ab", ab, FLOAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end
endmodule
